// File: rtl/program_ram_loader.sv
// Writable program RAM that loads a little-endian byte stream and holds the core
// in reset until the load completes. It then serves instruction fetches the way the ROM did.
module program_ram_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_words,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  core_reset_n,
  input  logic [31:0]           program_addr_bus,
  output logic [31:0]           program_data_bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           load_checksum
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   ONE_W     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]            HOLD_INIT = 4'(RESET_HOLD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] word_ptr;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [1:0]            byte_cnt;
  logic [23:0]           staging;
  logic [3:0]            hold_cnt;
  logic [31:0]           mem [0:(1<<ADDR_WIDTH)-1];

  logic                  words_ok;
  logic [ADDR_WIDTH:0]   words_m1;
  logic                  byte_fire;
  logic                  word_fire;
  logic [31:0]           wdata;
  logic                  unused_addr;

  assign words_ok    = (load_words != '0) && (load_words <= DEPTH_W);
  assign words_m1    = load_words - ONE_W;
  assign byte_fire   = (state == LOAD) && byte_ready && byte_valid;
  assign word_fire   = byte_fire && (byte_cnt == 2'd3);
  assign wdata       = {byte_data, staging};
  assign unused_addr = ^program_addr_bus[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      word_ptr      <= '0;
      last_idx      <= '0;
      byte_cnt      <= '0;
      staging       <= '0;
      hold_cnt      <= '0;
      byte_ready    <= 1'b0;
      core_reset_n  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      load_checksum <= '0;
    end else begin
      unique case (state)
        IDLE, RUN: begin
          if (load_start) begin
            if (words_ok) begin
              state         <= LOAD;
              last_idx      <= words_m1[ADDR_WIDTH-1:0];
              word_ptr      <= '0;
              byte_cnt      <= '0;
              load_checksum <= '0;
              error         <= 1'b0;
              byte_ready    <= 1'b1;
              busy          <= 1'b1;
              done          <= 1'b0;
              core_reset_n  <= 1'b0;
            end else begin
              error <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (byte_fire) begin
            if (byte_cnt == 2'd3) begin
              load_checksum <= load_checksum + wdata;
              byte_cnt      <= '0;
              // pointer stops on the final word so it never wraps past depth-1
              if (word_ptr == last_idx) begin
                state      <= RELEASE;
                byte_ready <= 1'b0;
                hold_cnt   <= HOLD_INIT;
              end else begin
                word_ptr <= word_ptr + PTR_ONE;
              end
            end else begin
              case (byte_cnt)
                2'd0:    staging[7:0]   <= byte_data;
                2'd1:    staging[15:8]  <= byte_data;
                default: staging[23:16] <= byte_data;
              endcase
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        RELEASE: begin
          if (hold_cnt == '0) begin
            state        <= RUN;
            busy         <= 1'b0;
            done         <= 1'b1;
            core_reset_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // memory has no reset so a mid-load reset keeps already written words
  always_ff @(posedge clk) begin
    if (word_fire) mem[word_ptr] <= wdata;
  end

  always_comb begin
    if (program_addr_bus[31:ADDR_WIDTH+2] != '0)
      program_data_bus = 32'h0000_0013;
    else
      program_data_bus = mem[program_addr_bus[ADDR_WIDTH+1:2]];
  end

endmodule

// File: tb/tb_program_ram_loader.sv
// Directed bench for program_ram_loader: byte loading, handshake stalls, error
// handling, reload from RUN, mid-load reset and the fetch port.
`timescale 1ns/1ps
module tb_program_ram_loader;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [AW:0] load_words = '0;
  logic [7:0]  byte_data = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        core_reset_n;
  logic [31:0] program_addr_bus = '0;
  logic [31:0] program_data_bus;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] load_checksum;

  program_ram_loader #(.ADDR_WIDTH(AW), .RESET_HOLD(4)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_words(load_words),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .core_reset_n(core_reset_n), .program_addr_bus(program_addr_bus),
    .program_data_bus(program_data_bus), .busy(busy), .done(done), .error(error),
    .load_checksum(load_checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } fetch_vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  stim [16];
  fetch_vec_t  fv [7];
  int          rc;
  int          hold;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic set_words(input logic [31:0] a, input logic [31:0] b);
    for (int k = 0; k < 4; k++) begin
      stim[k]     = a[8*k +: 8];
      stim[4 + k] = b[8*k +: 8];
    end
  endtask

  task automatic start_load(input logic [AW:0] n);
    load_start = 1'b1;
    load_words = n;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_bytes(input int nbytes, input bit toggle, output int rdy_cnt);
    int   idx;
    int   cyc;
    bit   v;
    logic r;
    idx = 0;
    cyc = 0;
    rdy_cnt = 0;
    while (idx < nbytes && cyc < 200) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      byte_valid = v;
      byte_data  = stim[idx];
      r = byte_ready;
      if (r) rdy_cnt++;
      @(posedge clk); #1;
      cyc++;
      if (v && r) idx++;
    end
    byte_valid = 1'b0;
    chk("byte_budget", idx, nbytes);
  endtask

  task automatic wait_release(output int cyc);
    cyc = 0;
    while (!core_reset_n && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic fetch(input string name, input logic [31:0] addr, input logic [31:0] exp);
    program_addr_bus = addr;
    #1;
    chk(name, program_data_bus, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim[0] = 8'h13; stim[1]  = 8'h05; stim[2]  = 8'h50; stim[3]  = 8'h00;
    stim[4] = 8'h93; stim[5]  = 8'h05; stim[6]  = 8'hA0; stim[7]  = 8'h00;
    stim[8] = 8'h33; stim[9]  = 8'h86; stim[10] = 8'hB5; stim[11] = 8'h00;
    fv[0] = '{32'h0000_0000, 32'h0050_0513};
    fv[1] = '{32'h0000_0004, 32'h00A0_0593};
    fv[2] = '{32'h0000_0008, 32'h00B5_8633};
    fv[3] = '{32'h0000_0006, 32'h00A0_0593};
    fv[4] = '{32'h0000_0001, 32'h0050_0513};
    fv[5] = '{32'h0000_0400, 32'h0000_0013};
    fv[6] = '{32'hFFFF_FFFC, 32'h0000_0013};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_reset_n", core_reset_n, 0);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_checksum", load_checksum, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    start_load(0);
    chk("zero_error", error, 1);
    chk("zero_busy", busy, 0);
    chk("zero_byte_ready", byte_ready, 0);
    chk("zero_core_reset_n", core_reset_n, 0);
    start_load(257);
    chk("big_error", error, 1);
    chk("big_busy", busy, 0);

    start_load(3);
    chk("load_error_clear", error, 0);
    chk("load_byte_ready", byte_ready, 1);
    chk("load_busy", busy, 1);
    send_bytes(12, 1'b0, rc);
    chk("ready_cycles", rc, 12);
    chk("post_byte_ready", byte_ready, 0);
    chk("release_busy", busy, 1);
    chk("release_core_reset_n", core_reset_n, 0);
    wait_release(hold);
    chk("hold_cycles", hold, 4);
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("checksum_a", load_checksum, 32'h0050_0513 + 32'h00A0_0593 + 32'h00B5_8633);
    for (int i = 0; i < 7; i++) begin
      program_addr_bus = fv[i].addr;
      #1;
      chk($sformatf("fetch_vec_%0d", i), program_data_bus, fv[i].exp);
    end

    start_load(0);
    chk("run_bad_error", error, 1);
    chk("run_bad_done", done, 1);
    chk("run_bad_core_reset_n", core_reset_n, 1);

    start_load(3);
    chk("reload_core_reset_n", core_reset_n, 0);
    chk("reload_done", done, 0);
    chk("reload_error_clear", error, 0);
    send_bytes(12, 1'b1, rc);
    wait_release(hold);
    chk("toggle_hold_cycles", hold, 4);
    chk("checksum_b", load_checksum, 32'h0050_0513 + 32'h00A0_0593 + 32'h00B5_8633);
    fetch("toggle_w0", 32'h0, 32'h0050_0513);
    fetch("toggle_w1", 32'h4, 32'h00A0_0593);
    fetch("toggle_w2", 32'h8, 32'h00B5_8633);

    set_words(32'h1122_3344, 32'h5566_7788);
    start_load(2);
    send_bytes(8, 1'b0, rc);
    wait_release(hold);
    chk("pre_checksum", load_checksum, 32'h1122_3344 + 32'h5566_7788);
    set_words(32'hCAFE_F00D, 32'hDEAD_BEEF);
    start_load(2);
    send_bytes(6, 1'b0, rc);
    reset = 1'b0;
    #1;
    chk("midrst_byte_ready", byte_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_core_reset_n", core_reset_n, 0);
    chk("midrst_checksum", load_checksum, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    fetch("midrst_w0", 32'h0, 32'hCAFE_F00D);
    fetch("midrst_w1", 32'h4, 32'h5566_7788);
    @(posedge clk); #1;
    start_load(2);
    send_bytes(8, 1'b0, rc);
    wait_release(hold);
    chk("final_done", done, 1);
    chk("final_checksum", load_checksum, 32'hCAFE_F00D + 32'hDEAD_BEEF);
    fetch("final_w0", 32'h0, 32'hCAFE_F00D);
    fetch("final_w1", 32'h4, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
